// File: rtl/gpo_1_driver.sv
// Avalon-MM general-purpose output register with atomic set/clear and
// self-clearing pulse bits driven onto a registered 32-bit gpo bus.
module gpo_1_driver #(
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter logic [31:0] IMPL_MASK    = 32'hFFFF_FFFF,
    parameter int unsigned PULSE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        srst,
    input  logic [1:0]  avmm_address,
    input  logic        avmm_write,
    input  logic [31:0] avmm_writedata,
    input  logic        avmm_read,
    output logic [31:0] avmm_readdata,
    output logic [31:0] gpo,
    output logic        pulse_active
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ADDR_WRITE = 2'd0,
        ADDR_SET   = 2'd1,
        ADDR_CLEAR = 2'd2,
        ADDR_PULSE = 2'd3
    } reg_addr_e;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

    logic [31:0]      gpo_q, gpo_nxt;
    logic [31:0]      pulse_mask, mask_nxt;
    logic [CNT_W-1:0] pulse_cnt, cnt_nxt;
    logic [31:0]      readdata_q, rd_data;
    logic             pulse_active_q;
    logic [31:0]      wr_bits;
    logic             pulse_wr;
    logic             expire;
    reg_addr_e        addr;
    pulse_state_e     pulse_state;

    assign addr        = reg_addr_e'(avmm_address);
    assign wr_bits     = avmm_writedata & IMPL_MASK;
    assign pulse_wr    = avmm_write && (addr == ADDR_PULSE);
    assign pulse_state = (pulse_cnt != '0) ? PULSE_ACTIVE : PULSE_IDLE;
    // A PULSE write landing on the last count reloads instead of expiring.
    assign expire      = (pulse_cnt == CNT_ONE) && !pulse_wr;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (no latch).
        gpo_nxt  = gpo_q;
        mask_nxt = pulse_mask;
        cnt_nxt  = pulse_cnt;

        if (pulse_state == PULSE_ACTIVE) begin
            cnt_nxt = pulse_cnt - CNT_ONE;
        end
        if (expire) begin
            gpo_nxt  = gpo_q & ~pulse_mask;
            mask_nxt = '0;
        end

        // The write is layered on top of any expiry so it wins for its bits.
        if (avmm_write) begin
            unique case (addr)
                ADDR_WRITE: begin
                    gpo_nxt  = wr_bits;
                    mask_nxt = '0;
                    cnt_nxt  = '0;
                end
                ADDR_SET: begin
                    gpo_nxt = gpo_nxt | wr_bits;
                end
                ADDR_CLEAR: begin
                    gpo_nxt  = gpo_nxt & ~wr_bits;
                    mask_nxt = mask_nxt & ~wr_bits;
                end
                ADDR_PULSE: begin
                    gpo_nxt  = gpo_nxt | wr_bits;
                    mask_nxt = mask_nxt | wr_bits;
                    cnt_nxt  = CNT_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (addr)
            ADDR_WRITE: rd_data = gpo_q;
            ADDR_SET:   rd_data = pulse_mask;
            ADDR_CLEAR: rd_data = 32'(pulse_cnt);
            ADDR_PULSE: rd_data = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (srst) begin
            gpo_q          <= RESET_VALUE & IMPL_MASK;
            pulse_mask     <= '0;
            pulse_cnt      <= '0;
            readdata_q     <= '0;
            pulse_active_q <= 1'b0;
        end else begin
            gpo_q          <= gpo_nxt;
            pulse_mask     <= mask_nxt;
            pulse_cnt      <= cnt_nxt;
            pulse_active_q <= (mask_nxt != '0);
            if (avmm_read) begin
                readdata_q <= rd_data;
            end
        end
    end

    assign gpo           = gpo_q;
    assign pulse_active  = pulse_active_q;
    assign avmm_readdata = readdata_q;

endmodule

// File: tb/tb_gpo_1_driver.sv
// Self-checking bench for gpo_1_driver: reads go through an expected-value
// queue; gpo and pulse_active are checked against cycle-counted constants.
module tb_gpo_1_driver;

    localparam logic [31:0] RST_VAL = 32'h0000_0081;
    localparam logic [31:0] IMPL    = 32'h0000_03FF;
    localparam int          PCYC    = 16;

    logic        clk = 1'b0;
    logic        srst;
    logic [1:0]  avmm_address;
    logic        avmm_write;
    logic [31:0] avmm_writedata;
    logic        avmm_read;
    logic [31:0] avmm_readdata;
    logic [31:0] gpo;
    logic        pulse_active;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    gpo_1_driver #(
        .RESET_VALUE (RST_VAL),
        .IMPL_MASK   (IMPL),
        .PULSE_CYCLES(PCYC)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .avmm_address  (avmm_address),
        .avmm_write    (avmm_write),
        .avmm_writedata(avmm_writedata),
        .avmm_read     (avmm_read),
        .avmm_readdata (avmm_readdata),
        .gpo           (gpo),
        .pulse_active  (pulse_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avmm_address   = a;
        avmm_writedata = d;
        avmm_write     = 1'b1;
        @(posedge clk);
        #1;
        avmm_write = 1'b0;
    endtask

    // Expected value is queued with the read strobe, compared when readdata lands.
    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] e;
        avmm_address = a;
        avmm_read    = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        avmm_read = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: readdata=%h with empty scoreboard", name, avmm_readdata);
        end else begin
            e = exp_q.pop_front();
            if (avmm_readdata !== e) begin
                failures++;
                $display("FAIL %s: readdata=%h expected=%h", name, avmm_readdata, e);
            end
        end
    endtask

    task automatic chk_gpo(input logic [31:0] exp, input string name);
        checks++;
        if (gpo !== exp) begin
            failures++;
            $display("FAIL %s: gpo=%h expected=%h", name, gpo, exp);
        end
    endtask

    task automatic chk_act(input logic exp, input string name);
        checks++;
        if (pulse_active !== exp) begin
            failures++;
            $display("FAIL %s: pulse_active=%b expected=%b", name, pulse_active, exp);
        end
    endtask

    task automatic test_reset;
        srst = 1'b1;
        avmm_write = 1'b0;
        avmm_read = 1'b0;
        avmm_address = 2'd0;
        avmm_writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
        chk_gpo(32'h81, "reset_gpo");
        chk_act(1'b0, "reset_active");
        checks++;
        if (avmm_readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_readdata: readdata=%h expected=%h", avmm_readdata, 32'h0);
        end
        bus_write(2'd0, 32'hFFFF_FFFF);
        chk_gpo(32'h3FF, "write_impl_mask");
        bus_read(2'd0, 32'h3FF, "read_impl_mask");
    endtask

    task automatic test_set_clear;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h0C);
        chk_gpo(32'h0C, "set_0c");
        bus_write(2'd2, 32'h04);
        chk_gpo(32'h08, "clear_04");
        bus_read(2'd0, 32'h08, "read_after_clear");
    endtask

    task automatic test_back_to_back;
        bus_write(2'd0, 32'h0);
        bus_write(2'd1, 32'h1);
        bus_write(2'd1, 32'h2);
        bus_write(2'd2, 32'h1);
        bus_write(2'd1, 32'h200);
        chk_gpo(32'h202, "b2b_writes");
        bus_write(2'd1, 32'hFFFF_FC00);
        chk_gpo(32'h202, "set_unimpl_bits");
        bus_write(2'd0, 32'h0AA);
        // Read and write in the same cycle return the pre-write value.
        avmm_read = 1'b1;
        exp_q.push_back(32'h0AA);
        bus_write(2'd0, 32'h155);
        avmm_read = 1'b0;
        checks++;
        if (avmm_readdata !== exp_q[0]) begin
            failures++;
            $display("FAIL read_write_same: readdata=%h expected=%h", avmm_readdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
        chk_gpo(32'h155, "rw_gpo_after");
        avmm_address = 2'd1;
        idle(2);
        checks++;
        if (avmm_readdata !== 32'h0AA) begin
            failures++;
            $display("FAIL readdata_hold: readdata=%h expected=%h", avmm_readdata, 32'h0AA);
        end
    endtask

    task automatic test_pulse_width;
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        for (int i = 1; i <= PCYC; i++) begin
            chk_gpo(32'h10, "pulse_high");
            chk_act(1'b1, "pulse_active_high");
            if (i == 4) begin
                avmm_address = 2'd2;
                avmm_read = 1'b1;
                exp_q.push_back(32'(PCYC + 1 - i));
            end else if (i == 8) begin
                avmm_address = 2'd1;
                avmm_read = 1'b1;
                exp_q.push_back(32'h10);
            end
            @(posedge clk);
            #1;
            if (avmm_read) begin
                avmm_read = 1'b0;
                checks++;
                if (avmm_readdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL mid_pulse_read: readdata=%h expected=%h", avmm_readdata, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        chk_gpo(32'h0, "pulse_low_after");
        chk_act(1'b0, "pulse_active_low_after");
        bus_read(2'd1, 32'h0, "mask_after_pulse");
        bus_read(2'd2, 32'h0, "cnt_after_pulse");
    endtask

    task automatic test_pulse_extend;
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        idle(9);
        bus_write(2'd3, 32'h20);
        chk_gpo(32'h30, "extend_both_high");
        idle(15);
        chk_gpo(32'h30, "extend_last_high");
        chk_act(1'b1, "extend_active");
        idle(1);
        chk_gpo(32'h0, "extend_both_low");
        chk_act(1'b0, "extend_inactive");
        // A PULSE with no implemented bits still reloads the counter.
        bus_write(2'd3, 32'h10);
        idle(4);
        bus_write(2'd3, 32'hFFFF_0000);
        idle(15);
        chk_gpo(32'h10, "zero_pulse_reload_high");
        idle(1);
        chk_gpo(32'h0, "zero_pulse_reload_low");
    endtask

    task automatic test_expiry_collisions;
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        idle(15);
        bus_write(2'd1, 32'h10);
        chk_gpo(32'h10, "set_on_expiry");
        chk_act(1'b0, "set_on_expiry_active");
        bus_read(2'd1, 32'h0, "set_on_expiry_mask");
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        idle(15);
        bus_write(2'd0, 32'h30);
        chk_gpo(32'h30, "write_on_expiry");
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        idle(15);
        bus_write(2'd3, 32'h20);
        chk_gpo(32'h30, "pulse_on_expiry");
        idle(15);
        chk_gpo(32'h30, "pulse_on_expiry_held");
        idle(1);
        chk_gpo(32'h0, "pulse_on_expiry_low");
    endtask

    task automatic test_write_clear_midpulse;
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        idle(5);
        bus_write(2'd0, 32'h0);
        chk_gpo(32'h0, "write0_mid_gpo");
        chk_act(1'b0, "write0_mid_active");
        bus_read(2'd2, 32'h0, "write0_mid_cnt");
        bus_write(2'd3, 32'h30);
        bus_write(2'd2, 32'h20);
        chk_gpo(32'h10, "clear_partial_gpo");
        bus_read(2'd1, 32'h10, "clear_partial_mask");
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h30);
        bus_write(2'd2, 32'h30);
        chk_act(1'b0, "clear_empty_active");
        bus_write(2'd1, 32'h30);
        bus_read(2'd2, 32'(PCYC - 2), "clear_empty_cnt_runs");
        idle(13);
        chk_gpo(32'h30, "clear_empty_expiry_noop");
        bus_read(2'd2, 32'h0, "clear_empty_cnt_done");
    endtask

    task automatic test_reset_midpulse;
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'h10);
        bus_read(2'd0, 32'h10, "pre_reset_read");
        idle(3);
        srst = 1'b1;
        avmm_address = 2'd3;
        avmm_writedata = 32'h40;
        avmm_write = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        avmm_write = 1'b0;
        chk_gpo(RST_VAL & IMPL, "reset_mid_gpo");
        chk_act(1'b0, "reset_mid_active");
        checks++;
        if (avmm_readdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_readdata: readdata=%h expected=%h", avmm_readdata, 32'h0);
        end
        bus_read(2'd1, 32'h0, "reset_mid_mask");
        bus_read(2'd2, 32'h0, "reset_mid_cnt");
        for (int i = 0; i < PCYC + 4; i++) begin
            idle(1);
            chk_gpo(RST_VAL & IMPL, "reset_no_expiry");
        end
    endtask

    initial begin
        test_reset();
        test_set_clear();
        test_back_to_back();
        test_pulse_width();
        test_pulse_extend();
        test_expiry_collisions();
        test_write_clear_midpulse();
        test_reset_midpulse();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpo_1_driver.md
# gpo_1_driver

General-purpose output (GPO) register block: the outbound counterpart of the GPI_1 input word. The Nios firmware writes platform control bits through an Avalon-MM slave port, and the block drives them as a registered 32-bit `gpo` bus to the platform control logic. It supports full-word write, atomic set, atomic clear and self-clearing pulse writes, so firmware can assert timed strobes such as rearm or force-recovery pulses without tracking timing itself.

## Interface
- `RESET_VALUE`, default 32'h0: value loaded into `gpo` on reset.
- `IMPL_MASK`, default 32'hFFFF_FFFF: implemented bits. Unimplemented bits are forced to 0 on `gpo` and on readback.
- `PULSE_CYCLES`, default 16: pulse width in `clk` cycles. Legal range is 1 to 65535.

- `clk` input 1: the single clock.
- `srst` input 1: synchronous, active-high reset.
- `avmm_address` input 2: word address. 0 = WRITE, 1 = SET, 2 = CLEAR, 3 = PULSE.
- `avmm_write` input 1: write strobe. Each asserted cycle is one write; there is no waitrequest.
- `avmm_writedata` input 32: write data or bit mask.
- `avmm_read` input 1: read strobe.
- `avmm_readdata` output 32: read data, valid exactly 1 cycle after `avmm_read`.
- `gpo` output 32: registered output bus.
- `pulse_active` output 1: high while any pulse bit is pending.

## Operation
State registers:
- `gpo_q` (32)
- `pulse_mask` (32)
- `pulse_cnt`, width $clog2(PULSE_CYCLES+1)

Reset (`srst`=1 at a rising edge), which overrides every other event including a same-cycle write:
- `gpo_q` = RESET_VALUE & IMPL_MASK
- `pulse_mask` = 0, `pulse_cnt` = 0
- `avmm_readdata` = 0, `pulse_active` = 0
- A pulse in flight is abandoned.

Write decode, with `d = avmm_writedata & IMPL_MASK`:
- WRITE (0): `gpo_q` = d; `pulse_mask` = 0; `pulse_cnt` = 0.
- SET (1): `gpo_q` |= d.
- CLEAR (2): `gpo_q` &= ~d; `pulse_mask` &= ~d.
- PULSE (3): `gpo_q` |= d; `pulse_mask` |= d; `pulse_cnt` = PULSE_CYCLES. A write with d = 0 still reloads the counter but leaves `pulse_mask` unchanged.

Pulse engine:
- States are IDLE (`pulse_cnt` = 0) and ACTIVE (`pulse_cnt` > 0).
- In ACTIVE, `pulse_cnt` decrements by 1 each cycle.
- Expiry is the cycle in which `pulse_cnt` = 1 and no PULSE write is accepted. On the next edge: `gpo_q` &= ~`pulse_mask`, `pulse_mask` = 0, `pulse_cnt` = 0, and the engine returns to IDLE.
- Bits set by SET or WRITE are never affected by expiry unless they are also in `pulse_mask`.

Simultaneous events:
- Expiry and a write in the same cycle: the expiry clear is applied first, then the write on top of the result, so the write wins for the bits it touches.
- Expiry and SET in the same cycle: a SET of a pulsed bit leaves that bit at 1 after expiry.
- Expiry and PULSE in the same cycle: no expiry occurs. The counter reloads and the mask ORs in d.
- CLEAR that empties `pulse_mask`: `pulse_cnt` keeps counting, and the eventual expiry clears nothing.

Readback:
- Address 0 returns `gpo_q`.
- Address 1 returns `pulse_mask`.
- Address 2 returns `pulse_cnt`, zero-extended.
- Address 3 returns 0.

Outputs:
- `pulse_active` = (`pulse_mask` != 0), registered.
- `gpo` = `gpo_q`, with no combinational path from any input to `gpo`.

## Timing
- A write accepted at edge N is visible on `gpo` after edge N, i.e. during cycle N+1.
- Pulse width: with a PULSE write at edge N and no further writes, the bit is high for exactly PULSE_CYCLES cycles (N+1 through N+PULSE_CYCLES) and low from cycle N+PULSE_CYCLES+1.
- Read latency is fixed at 1 cycle. A read and a write in the same cycle return the pre-write value.
- `avmm_readdata` holds its last value when `avmm_read` = 0.
- Back-to-back writes are accepted on every cycle.

## Test plan
- Reset, with RESET_VALUE = 32'h0000_0081 and IMPL_MASK = 32'h0000_03FF → `gpo` = 32'h81, `pulse_active` = 0, readdata = 0. A later WRITE of 32'hFFFF_FFFF → `gpo` = 32'h3FF.
- SET 32'h0C, then CLEAR 32'h04 from `gpo` = 0 → `gpo` = 32'h0C, then 32'h08. Read addr 0 one cycle later → 32'h08.
- PULSE 32'h10 with PULSE_CYCLES = 16 → bit 4 high for exactly 16 cycles; `pulse_active` high over the same window; `pulse_mask` reads 32'h10 mid-pulse and 0 afterwards.
- PULSE 32'h10 at cycle 0, then PULSE 32'h20 at cycle 10 → both bits fall together at cycle 27.
- SET 32'h10 in the expiry cycle of a pulse on 32'h10 → bit 4 stays 1 after expiry. Separately, WRITE 0 mid-pulse → `gpo` = 0, `pulse_active` = 0, `pulse_cnt` reads 0.
- Assert `srst` mid-pulse together with a PULSE write → `gpo` = RESET_VALUE & IMPL_MASK, `pulse_mask` = 0, `pulse_cnt` = 0, and no later expiry edge occurs.
